// File: rtl/vm_pkg.sv
// Shared definitions for the byte-to-element path; the element width default lives
// here so the assembler and the element controller cannot disagree.
package vm_pkg;

  localparam int BYTE_W                = 8;
  localparam int DEFAULT_ELEMENT_WIDTH = 3;

  typedef enum logic {
    ASM_IDLE    = 1'b0,
    ASM_COLLECT = 1'b1
  } asm_state_t;

  // Bits needed to count 0..limit-1, never less than one.
  function automatic int timer_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/element_assembler_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles, pulses expire combinationally on the
// last allowed cycle; a LIMIT of 0 disables it entirely.
module idle_timer #(
  parameter int LIMIT = 100000,
  parameter int WIDTH = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  generate
    if (LIMIT == 0) begin : g_off
      logic unused;
      assign unused = &{1'b0, clk, reset, enable, clear};
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
      logic [WIDTH-1:0] count;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= (count == LAST) ? '0 : count + 1'b1;
        end
      end

      // A clear in the final cycle (a byte or flush arriving) suppresses the expiry.
      assign expire = enable && !clear && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/element_assembler.sv
// Packs ELEMENT_WIDTH bytes MSB-first into one element, pulsing element_ready 1 clk after
// the final byte; no backpressure. Stale partials are dropped on idle timeout or flush.
module element_assembler
  import vm_pkg::*;
#(
  parameter int ELEMENT_WIDTH  = DEFAULT_ELEMENT_WIDTH,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BYTE_W-1:0]                 byte_in,
  input  logic                              byte_valid,
  input  logic                              flush,
  output logic [ELEMENT_WIDTH*BYTE_W-1:0]   element,
  output logic                              element_ready,
  output logic [$clog2(ELEMENT_WIDTH):0]    byte_index,
  output logic                              timeout_err,
  output logic [COUNT_WIDTH-1:0]            element_count
);

  localparam int                EW_BITS  = ELEMENT_WIDTH * BYTE_W;
  localparam int                IDX_W    = $clog2(ELEMENT_WIDTH) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ELEMENT_WIDTH - 1);
  localparam int                TMR_W    = timer_width(TIMEOUT_CYCLES);

  asm_state_t          state;
  logic [EW_BITS-1:0]  shreg;
  logic [EW_BITS-1:0]  base_word;
  logic [EW_BITS-1:0]  packed_word;
  logic                last_byte;
  logic                timer_en;
  logic                timer_clear;
  logic                expire;

  // In IDLE the register contents are ignored, so the first byte lands alone in the
  // low byte and reaches the top after ELEMENT_WIDTH-1 further shifts.
  always_comb begin
    base_word = '0;
    if (state == ASM_COLLECT) begin
      base_word = shreg;
    end
  end

  assign packed_word = (base_word << BYTE_W) | EW_BITS'(byte_in);
  assign last_byte   = (byte_index == LAST_IDX);
  assign timer_en    = (state == ASM_COLLECT);
  assign timer_clear = byte_valid || flush || (state == ASM_IDLE);

  idle_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TMR_W)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en),
    .clear  (timer_clear),
    .expire (expire)
  );

  // Priority: flush, then an arriving byte, then timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ASM_IDLE;
      shreg         <= '0;
      byte_index    <= '0;
      element       <= '0;
      element_ready <= 1'b0;
      timeout_err   <= 1'b0;
      element_count <= '0;
    end else begin
      element_ready <= 1'b0;
      timeout_err   <= 1'b0;
      if (flush) begin
        state      <= ASM_IDLE;
        shreg      <= '0;
        byte_index <= '0;
      end else if (byte_valid) begin
        if (last_byte) begin
          element       <= packed_word;
          element_ready <= 1'b1;
          element_count <= element_count + 1'b1;
          shreg         <= '0;
          byte_index    <= '0;
          state         <= ASM_IDLE;
        end else begin
          shreg      <= packed_word;
          byte_index <= byte_index + 1'b1;
          state      <= ASM_COLLECT;
        end
      end else if (expire) begin
        state       <= ASM_IDLE;
        shreg       <= '0;
        byte_index  <= '0;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_element_assembler.sv
// Bench for element_assembler: a 3-byte instance with an 8-cycle timeout and a
// 1-byte instance with a 4-bit counter, checked by table rows plus a scoreboard.
module tb_element_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  a_byte, b_byte;
  logic        a_vld, b_vld, a_flush, b_flush;
  logic [23:0] a_elem;
  logic        a_rdy, a_to;
  logic [2:0]  a_idx;
  logic [15:0] a_cnt;
  logic [7:0]  b_elem;
  logic        b_rdy, b_to;
  logic [0:0]  b_idx;
  logic [3:0]  b_cnt;

  element_assembler #(.ELEMENT_WIDTH(3), .TIMEOUT_CYCLES(8), .COUNT_WIDTH(16)) u_dut_a (
    .clk(clk), .reset(reset), .byte_in(a_byte), .byte_valid(a_vld), .flush(a_flush),
    .element(a_elem), .element_ready(a_rdy), .byte_index(a_idx),
    .timeout_err(a_to), .element_count(a_cnt)
  );

  element_assembler #(.ELEMENT_WIDTH(1), .TIMEOUT_CYCLES(0), .COUNT_WIDTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .byte_in(b_byte), .byte_valid(b_vld), .flush(b_flush),
    .element(b_elem), .element_ready(b_rdy), .byte_index(b_idx),
    .timeout_err(b_to), .element_count(b_cnt)
  );

  typedef struct { logic [23:0] elem; logic [15:0] cnt; } exp_a_t;
  typedef struct { logic [7:0]  elem; logic [3:0]  cnt; } exp_b_t;
  typedef struct {
    logic v; logic [7:0] b; logic f;
    logic [2:0] idx; logic rdy; logic to; logic [23:0] elem;
  } vec_t;

  exp_a_t a_q[$];
  exp_b_t b_q[$];
  vec_t   tbl[$];

  int checks = 0;
  int errors = 0;
  int a_to_pulses = 0;
  int b_to_pulses = 0;
  int b_rdy_pulses = 0;
  logic [15:0] exp_a_cnt = '0;
  logic [3:0]  exp_b_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] b, input logic f, input logic [2:0] idx,
                     input logic rdy, input logic to, input logic [23:0] elem);
    vec_t r;
    r.v = v; r.b = b; r.f = f; r.idx = idx; r.rdy = rdy; r.to = to; r.elem = elem;
    tbl.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_elem"}, 32'(a_elem), 32'h0);
    check({tag, "_a_rdy"},  32'(a_rdy),  32'h0);
    check({tag, "_a_idx"},  32'(a_idx),  32'h0);
    check({tag, "_a_to"},   32'(a_to),   32'h0);
    check({tag, "_a_cnt"},  32'(a_cnt),  32'h0);
    check({tag, "_b_elem"}, 32'(b_elem), 32'h0);
    check({tag, "_b_cnt"},  32'(b_cnt),  32'h0);
  endtask

  // Scoreboard: every element_ready must match the oldest expected completion.
  always @(negedge clk) begin
    if (a_rdy) begin
      if (a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_ready: got element %h, expected no pulse", a_elem);
      end else begin
        exp_a_t e;
        e = a_q.pop_front();
        check("a_sb_element", 32'(a_elem), 32'(e.elem));
        check("a_sb_count",   32'(a_cnt),  32'(e.cnt));
      end
    end
    if (b_rdy) begin
      b_rdy_pulses++;
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_ready: got element %h, expected no pulse", b_elem);
      end else begin
        exp_b_t e;
        e = b_q.pop_front();
        check("b_sb_element", 32'(b_elem), 32'(e.elem));
        check("b_sb_count",   32'(b_cnt),  32'(e.cnt));
      end
    end
    if (a_to) a_to_pulses++;
    if (b_to) b_to_pulses++;
  end

  task automatic drive_a(input logic [7:0] b, input logic last, input logic [23:0] elem);
    a_vld = 1'b1; a_byte = b;
    if (last) begin
      exp_a_cnt++;
      a_q.push_back('{elem, exp_a_cnt});
    end
    @(negedge clk);
  endtask

  initial begin
    // Basic pack
    add(1, 8'h12, 0, 1, 0, 0, 24'h0);
    add(1, 8'h34, 0, 2, 0, 0, 24'h0);
    add(1, 8'h56, 0, 0, 1, 0, 24'h123456);
    add(0, 8'h00, 0, 0, 0, 0, 24'h123456);
    // Gapped bytes inside the timeout window
    add(1, 8'hAA, 0, 1, 0, 0, 24'h123456);
    for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 1, 0, 0, 24'h123456);
    add(1, 8'hBB, 0, 2, 0, 0, 24'h123456);
    add(1, 8'hCC, 0, 0, 1, 0, 24'hAABBCC);
    // Timeout on the eighth idle cycle, then a clean element
    add(1, 8'h01, 0, 1, 0, 0, 24'hAABBCC);
    add(1, 8'h02, 0, 2, 0, 0, 24'hAABBCC);
    for (int i = 0; i < 7; i++) add(0, 8'h00, 0, 2, 0, 0, 24'hAABBCC);
    add(0, 8'h00, 0, 0, 0, 1, 24'hAABBCC);
    add(0, 8'h00, 0, 0, 0, 0, 24'hAABBCC);
    add(1, 8'h07, 0, 1, 0, 0, 24'hAABBCC);
    add(1, 8'h08, 0, 2, 0, 0, 24'hAABBCC);
    add(1, 8'h09, 0, 0, 1, 0, 24'h070809);
    // Flush colliding with a byte: the byte is discarded
    add(1, 8'h11, 0, 1, 0, 0, 24'h070809);
    add(1, 8'h22, 1, 0, 0, 0, 24'h070809);
    add(1, 8'h33, 0, 1, 0, 0, 24'h070809);
    add(1, 8'h44, 0, 2, 0, 0, 24'h070809);
    add(1, 8'h55, 0, 0, 1, 0, 24'h334455);
    // Byte during the ready cycle starts the next element
    add(1, 8'h66, 0, 1, 0, 0, 24'h334455);
    add(1, 8'h77, 0, 2, 0, 0, 24'h334455);
    add(1, 8'h88, 0, 0, 1, 0, 24'h667788);
    // Flush without a byte
    add(1, 8'h99, 0, 1, 0, 0, 24'h667788);
    add(0, 8'h00, 1, 0, 0, 0, 24'h667788);
    // Byte arriving in the would-be timeout cycle wins
    add(1, 8'hA1, 0, 1, 0, 0, 24'h667788);
    for (int i = 0; i < 7; i++) add(0, 8'h00, 0, 1, 0, 0, 24'h667788);
    add(1, 8'hA2, 0, 2, 0, 0, 24'h667788);
    add(1, 8'hA3, 0, 0, 1, 0, 24'hA1A2A3);

    reset = 1'b0;
    a_byte = '0; a_vld = 1'b0; a_flush = 1'b0;
    b_byte = '0; b_vld = 1'b0; b_flush = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      a_vld = tbl[i].v; a_byte = tbl[i].b; a_flush = tbl[i].f;
      if (tbl[i].rdy) begin
        exp_a_cnt++;
        a_q.push_back('{tbl[i].elem, exp_a_cnt});
      end
      @(negedge clk);
      check($sformatf("row%0d_idx", i),  32'(a_idx),  32'(tbl[i].idx));
      check($sformatf("row%0d_rdy", i),  32'(a_rdy),  32'(tbl[i].rdy));
      check($sformatf("row%0d_to", i),   32'(a_to),   32'(tbl[i].to));
      check($sformatf("row%0d_elem", i), 32'(a_elem), 32'(tbl[i].elem));
    end
    a_vld = 1'b0; a_flush = 1'b0;
    @(negedge clk);
    check("a_count_before_reset", 32'(a_cnt), 32'd6);

    // Reset in the middle of an element
    drive_a(8'hDE, 1'b0, 24'h0);
    drive_a(8'hAD, 1'b0, 24'h0);
    a_vld = 1'b0;
    check("midreset_idx_before", 32'(a_idx), 32'd2);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    check_all_zero("held_reset");
    exp_a_cnt = '0;
    exp_b_cnt = '0;
    reset = 1'b1;
    @(negedge clk);
    drive_a(8'h01, 1'b0, 24'h0);
    drive_a(8'h02, 1'b0, 24'h0);
    drive_a(8'h03, 1'b1, 24'h010203);
    a_vld = 1'b0;
    check("postreset_elem", 32'(a_elem), 32'h010203);
    check("postreset_cnt",  32'(a_cnt),  32'd1);
    repeat (2) @(negedge clk);

    // Single-byte elements back to back; counter wraps past 15
    for (int i = 0; i < 17; i++) begin
      b_vld = 1'b1;
      b_byte = 8'(i * 37 + 3);
      exp_b_cnt++;
      b_q.push_back('{b_byte, exp_b_cnt});
      @(negedge clk);
    end
    b_vld = 1'b0;
    @(negedge clk);
    check("b_count_wrap",   32'(b_cnt),        32'd1);
    check("b_ready_pulses", 32'(b_rdy_pulses), 32'd17);
    check("b_last_elem",    32'(b_elem),       32'(8'(16 * 37 + 3)));
    check("b_idx_idle",     32'(b_idx),        32'd0);

    repeat (2) @(negedge clk);
    check("a_timeout_pulses", 32'(a_to_pulses), 32'd1);
    check("b_timeout_pulses", 32'(b_to_pulses), 32'd0);
    check("a_pending",        32'(a_q.size()),  32'd0);
    check("b_pending",        32'(b_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
